// File: rtl/pio_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the PIO host-side sequencer.
// Pure declarations; no latency or flow-control behaviour of its own.
package pio_ctrl_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_IMEM_WR = 3'd1;
    localparam logic [2:0] OP_EN_SET  = 3'd2;
    localparam logic [2:0] OP_RESTART = 3'd3;
    localparam logic [2:0] OP_EXEC    = 3'd4;
    localparam logic [2:0] OP_IRQ_CLR = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        IMEM,
        RESTART,
        EXEC
    } pio_ctrl_state_t;

endpackage

// File: rtl/pio_irq_reg.sv
// Shared 8-bit IRQ flag register: OR of per-SM set/clear plus a host clear mask.
// Latency: a request is visible one cycle later. No backpressure; set beats clear.
module pio_irq_reg #(
    parameter int NUM_SM = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NUM_SM-1:0] sm_irq_set,
    input  logic [8*NUM_SM-1:0] sm_irq_clr,
    input  logic [7:0]          host_clr,
    output logic [7:0]          flags
);

    logic [7:0] set_any;
    logic [7:0] clr_any;

    always_comb begin
        set_any = '0;
        clr_any = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            set_any = set_any | sm_irq_set[8*i +: 8];
            clr_any = clr_any | sm_irq_clr[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~clr_any & ~host_clr) | set_any;
        end
    end

endmodule

// File: rtl/pio_ctrl.sv
// Host command sequencer for the PIO state machines; IRQ register built under PIO_CTRL_IRQ_EN.
// Latency: all effects registered, visible the cycle after acceptance.
// Backpressure: cmd_ready drops while an IMEM write, restart or EXEC is in flight.
module pio_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int NUM_SM  = 4,
    parameter int IMEM_AW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [IMEM_AW-1:0]  cmd_addr,
    input  logic [31:0]         cmd_data,
    output logic                cmd_err,
    output logic                imem_we,
    output logic [IMEM_AW-1:0]  imem_addr,
    output logic [15:0]         imem_wdata,
    output logic [NUM_SM-1:0]   sm_en,
    output logic [NUM_SM-1:0]   sm_restart,
    output logic [NUM_SM-1:0]   sm_imm,
    output logic [15:0]         imm_instr,
    input  logic [NUM_SM-1:0]   sm_penable,
    input  logic [8*NUM_SM-1:0] sm_irq_set,
    input  logic [8*NUM_SM-1:0] sm_irq_clr,
    output logic [7:0]          irq_flags
);

    pio_ctrl_state_t     state, state_nxt;
    logic [1:0]          exec_idx, exec_idx_nxt;
    logic [NUM_SM-1:0]   sm_en_nxt, sm_restart_nxt, sm_imm_nxt;
    logic [15:0]         imm_instr_nxt, imem_wdata_nxt;
    logic [IMEM_AW-1:0]  imem_addr_nxt;
    logic                imem_we_nxt, cmd_err_nxt;
    logic [7:0]          host_clr, host_clr_nxt;
    logic                accept, cmd_ok, exec_en, exec_pen;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // Target lookup done by loop so NUM_SM < 4 never indexes past the bank.
    always_comb begin
        cmd_ok   = 1'b0;
        exec_en  = 1'b0;
        exec_pen = 1'b0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (cmd_addr[1:0] == 2'(i) && sm_en[i]) cmd_ok = 1'b1;
            if (exec_idx == 2'(i)) begin
                exec_en  = sm_en[i];
                exec_pen = sm_penable[i];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        exec_idx_nxt   = exec_idx;
        sm_en_nxt      = sm_en;
        sm_restart_nxt = '0;
        sm_imm_nxt     = sm_imm;
        imm_instr_nxt  = imm_instr;
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr;
        imem_wdata_nxt = imem_wdata;
        cmd_err_nxt    = 1'b0;
        host_clr_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_IMEM_WR: begin
                            state_nxt      = IMEM;
                            imem_we_nxt    = 1'b1;
                            imem_addr_nxt  = cmd_addr;
                            imem_wdata_nxt = cmd_data[15:0];
                        end
                        OP_EN_SET: sm_en_nxt = cmd_data[NUM_SM-1:0];
                        OP_RESTART: begin
                            state_nxt      = RESTART;
                            sm_restart_nxt = cmd_data[NUM_SM-1:0];
                        end
                        OP_EXEC: begin
                            if (cmd_ok) begin
                                state_nxt     = EXEC;
                                exec_idx_nxt  = cmd_addr[1:0];
                                imm_instr_nxt = cmd_data[15:0];
                                for (int i = 0; i < NUM_SM; i++)
                                    sm_imm_nxt[i] = (cmd_addr[1:0] == 2'(i));
                            end else begin
                                cmd_err_nxt = 1'b1;
                            end
                        end
`ifdef PIO_CTRL_IRQ_EN
                        OP_IRQ_CLR: host_clr_nxt = cmd_data[7:0];
`endif
                        default: cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            IMEM:    state_nxt = IDLE;
            RESTART: state_nxt = IDLE;
            EXEC: begin
                if (!exec_en) begin
                    state_nxt   = IDLE;
                    sm_imm_nxt  = '0;
                    cmd_err_nxt = 1'b1;
                end else if (exec_pen) begin
                    state_nxt  = IDLE;
                    sm_imm_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            exec_idx   <= '0;
            sm_en      <= '0;
            sm_restart <= '0;
            sm_imm     <= '0;
            imm_instr  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cmd_err    <= 1'b0;
            host_clr   <= '0;
        end else begin
            state      <= state_nxt;
            exec_idx   <= exec_idx_nxt;
            sm_en      <= sm_en_nxt;
            sm_restart <= sm_restart_nxt;
            sm_imm     <= sm_imm_nxt;
            imm_instr  <= imm_instr_nxt;
            imem_we    <= imem_we_nxt;
            imem_addr  <= imem_addr_nxt;
            imem_wdata <= imem_wdata_nxt;
            cmd_err    <= cmd_err_nxt;
            host_clr   <= host_clr_nxt;
        end
    end

`ifdef PIO_CTRL_IRQ_EN
    pio_irq_reg #(.NUM_SM(NUM_SM)) u_irq (
        .clk        (clk),
        .reset      (reset),
        .sm_irq_set (sm_irq_set),
        .sm_irq_clr (sm_irq_clr),
        .host_clr   (host_clr),
        .flags      (irq_flags)
    );
    logic unused_bits;
    assign unused_bits = ^cmd_data[31:16];
`else
    assign irq_flags = '0;
    logic unused_bits;
    assign unused_bits = ^{cmd_data[31:16], sm_irq_set, sm_irq_clr, host_clr};
`endif

endmodule

// File: tb/tb_pio_ctrl.sv
// Directed-plus-random bench for pio_ctrl with a transaction-level expectation model.
module tb_pio_ctrl;

`ifdef PIO_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_err;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [3:0]  sm_en, sm_restart, sm_imm;
    logic [15:0] imm_instr;
    logic [3:0]  sm_penable;
    logic [31:0] sm_irq_set, sm_irq_clr;
    logic [7:0]  irq_flags;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_flags, m_hclr, pend_hclr;
    logic [3:0]  mask;
    logic [4:0]  ra;
    logic [15:0] rd;
    int          idx, dly;

    always #5 clk = ~clk;

    pio_ctrl #(.NUM_SM(4), .IMEM_AW(5)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(cmd_err),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .sm_en(sm_en), .sm_restart(sm_restart), .sm_imm(sm_imm),
        .imm_instr(imm_instr), .sm_penable(sm_penable),
        .sm_irq_set(sm_irq_set), .sm_irq_clr(sm_irq_clr), .irq_flags(irq_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the IRQ model follows the rule: clear by any SM or host, then OR in sets.
    task automatic tick();
        logic [7:0] s, c;
        s = '0;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            s = s | sm_irq_set[8*i +: 8];
            c = c | sm_irq_clr[8*i +: 8];
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_flags = '0;
            m_hclr  = '0;
        end else begin
            m_flags = (m_flags & ~c & ~m_hclr) | s;
            m_hclr  = pend_hclr;
        end
        pend_hclr = '0;
        chk("irq_flags", 32'(irq_flags), IRQ_EN ? 32'(m_flags) : 32'h0);
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] a, input logic [31:0] d);
        chk("ready_at_issue", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        if (op == 3'd5) pend_hclr = d[7:0];
        tick();
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},      32'(imem_we),    32'h0);
        chk({tag, "_addr"},    32'(imem_addr),  32'h0);
        chk({tag, "_wdata"},   32'(imem_wdata), 32'h0);
        chk({tag, "_en"},      32'(sm_en),      32'h0);
        chk({tag, "_restart"}, 32'(sm_restart), 32'h0);
        chk({tag, "_imm"},     32'(sm_imm),     32'h0);
        chk({tag, "_instr"},   32'(imm_instr),  32'h0);
        chk({tag, "_err"},     32'(cmd_err),    32'h0);
        chk({tag, "_flags"},   32'(irq_flags),  32'h0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        sm_penable = '0; sm_irq_set = '0; sm_irq_clr = '0;
        m_flags = '0; m_hclr = '0; pend_hclr = '0;

        // Reset state
        tick(); tick();
        chk_all_zero("rst");
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'h1);

        // IMEM write: one strobe, ready low exactly one cycle
        send(3'd1, 5'd5, 32'h0000_E081);
        chk("imem_we", 32'(imem_we), 32'h1);
        chk("imem_addr", 32'(imem_addr), 32'h5);
        chk("imem_wdata", 32'(imem_wdata), 32'hE081);
        chk("imem_busy", 32'(cmd_ready), 32'h0);
        tick();
        chk("imem_we_off", 32'(imem_we), 32'h0);
        chk("imem_ready", 32'(cmd_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            ra = 5'($urandom);
            rd = 16'($urandom);
            send(3'd1, ra, {16'($urandom), rd});
            chk("rimem_we", 32'(imem_we), 32'h1);
            chk("rimem_addr", 32'(imem_addr), 32'(ra));
            chk("rimem_wdata", 32'(imem_wdata), 32'(rd));
            tick();
            chk("rimem_we_off", 32'(imem_we), 32'h0);
        end

        // Enable then restart; enables untouched by restart
        send(3'd2, 5'd0, 32'h5);
        chk("en_set", 32'(sm_en), 32'h5);
        chk("en_ready", 32'(cmd_ready), 32'h1);
        send(3'd3, 5'd0, 32'h4);
        chk("restart_pulse", 32'(sm_restart), 32'h4);
        chk("restart_en", 32'(sm_en), 32'h5);
        chk("restart_busy", 32'(cmd_ready), 32'h0);
        tick();
        chk("restart_off", 32'(sm_restart), 32'h0);
        chk("restart_ready", 32'(cmd_ready), 32'h1);
        chk("restart_en2", 32'(sm_en), 32'h5);

        // EXEC directed: penable on SM1 four cycles after acceptance
        send(3'd2, 5'd0, 32'h2);
        send(3'd4, 5'd1, 32'h0000_A042);
        chk("exec_imm", 32'(sm_imm), 32'h2);
        chk("exec_instr", 32'(imm_instr), 32'hA042);
        chk("exec_busy", 32'(cmd_ready), 32'h0);
        sm_penable = 4'b1101;
        tick(); tick(); tick();
        chk("exec_hold", 32'(sm_imm), 32'h2);
        chk("exec_hold_busy", 32'(cmd_ready), 32'h0);
        sm_penable = 4'b0010;
        tick();
        sm_penable = '0;
        chk("exec_done_imm", 32'(sm_imm), 32'h0);
        chk("exec_done_ready", 32'(cmd_ready), 32'h1);
        chk("exec_done_err", 32'(cmd_err), 32'h0);

        // EXEC random targets and wait lengths
        for (int k = 0; k < 4; k++) begin
            mask = 4'($urandom_range(1, 15));
            idx  = $urandom_range(0, 3);
            while (!mask[idx]) idx = $urandom_range(0, 3);
            dly  = $urandom_range(0, 4);
            rd   = 16'($urandom);
            send(3'd2, 5'd0, 32'(mask));
            send(3'd4, 5'(idx), 32'(rd));
            chk("rexec_imm", 32'(sm_imm), 32'h1 << idx);
            chk("rexec_instr", 32'(imm_instr), 32'(rd));
            for (int j = 0; j < dly; j++) begin
                sm_penable = 4'hF & ~(4'h1 << idx);
                tick();
                chk("rexec_hold", 32'(sm_imm), 32'h1 << idx);
            end
            sm_penable = 4'h1 << idx;
            tick();
            sm_penable = '0;
            chk("rexec_done", 32'(sm_imm), 32'h0);
            chk("rexec_ready", 32'(cmd_ready), 32'h1);
        end

        // Error cases: disabled target, reserved opcodes, IRQ_CLR when not built
        send(3'd2, 5'd0, 32'h2);
        send(3'd4, 5'd2, 32'h1234);
        chk("err_dis", 32'(cmd_err), 32'h1);
        chk("err_dis_imm", 32'(sm_imm), 32'h0);
        chk("err_dis_ready", 32'(cmd_ready), 32'h1);
        tick();
        chk("err_dis_off", 32'(cmd_err), 32'h0);
        send(3'd6, 5'd0, 32'hFFFF);
        chk("err_op6", 32'(cmd_err), 32'h1);
        chk("err_op6_ready", 32'(cmd_ready), 32'h1);
        send(3'd7, 5'd0, 32'h0);
        chk("err_op7", 32'(cmd_err), 32'h1);
        chk("err_op7_en", 32'(sm_en), 32'h2);
        send(3'd0, 5'd0, 32'hFFFF_FFFF);
        chk("nop_err", 32'(cmd_err), 32'h0);
        chk("nop_en", 32'(sm_en), 32'h2);

        // IRQ: set beats clear, then clear alone, then host clear
        sm_irq_set = 32'h0000_0008;
        sm_irq_clr = 32'h0000_0800;
        tick();
        sm_irq_set = '0;
        tick();
        sm_irq_clr = '0;
        sm_irq_set = 32'h0000_00FF;
        tick();
        sm_irq_set = '0;
        send(3'd5, 5'd0, 32'hFF);
        chk("irqclr_err", 32'(cmd_err), IRQ_EN ? 32'h0 : 32'h1);
        tick();
        for (int k = 0; k < 30; k++) begin
            sm_irq_set = $urandom & $urandom & $urandom;
            sm_irq_clr = $urandom & $urandom;
            if (k == 15) send(3'd5, 5'd0, 32'($urandom));
            else tick();
        end
        sm_irq_set = '0;
        sm_irq_clr = '0;

        // Reset during EXEC wait
        sm_irq_set = 32'h0000_0300;
        tick();
        sm_irq_set = '0;
        send(3'd2, 5'd0, 32'h1);
        send(3'd4, 5'd0, 32'h0000_BEEF);
        tick();
        chk("pre_rst_imm", 32'(sm_imm), 32'h1);
        reset = 1'b1;
        tick();
        chk_all_zero("midrst");
        chk("midrst_ready", 32'(cmd_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("midrst_ready2", 32'(cmd_ready), 32'h1);
        tick();
        chk("midrst_imm2", 32'(sm_imm), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_ctrl.md
# pio_ctrl

Host-side sequencer for the PIO block. It accepts host commands over a valid/ready handshake and sequences them onto a bank of `NUM_SM` state machines and their shared instruction memory. Commands cover instruction-memory writes, enable masks, restart pulses and immediate-instruction injection. It also owns the shared 8-bit IRQ flag register that the state machines set, clear and wait on. It sits between the host bus adapter and the per-machine `en`/`restart`/`imm`/`irq_flags_in` inputs.

## Interface
Parameters:
- `NUM_SM`, 4, number of state machines controlled (1..4).
- `IMEM_AW`, 5, instruction memory address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode: 0 NOP, 1 IMEM_WR, 2 EN_SET, 3 RESTART, 4 EXEC, 5 IRQ_CLR, 6/7 reserved.
- `cmd_addr`  in  `IMEM_AW`  IMEM address (IMEM_WR) or SM index in `[1:0]` (EXEC).
- `cmd_data`  in  32  payload: instruction `[15:0]`, SM mask `[NUM_SM-1:0]` or IRQ mask `[7:0]`.
- `cmd_err`  out  1  one-cycle pulse: reserved opcode, EXEC to a disabled SM, or EXEC index ≥ `NUM_SM`.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  `IMEM_AW`  write address.
- `imem_wdata`  out  16  write data.
- `sm_en`  out  `NUM_SM`  per-machine enable.
- `sm_restart`  out  `NUM_SM`  per-machine restart pulse.
- `sm_imm`  out  `NUM_SM`  per-machine immediate-instruction flag.
- `imm_instr`  out  16  instruction injected with `sm_imm`.
- `sm_penable`  in  `NUM_SM`  per-machine divided clock enable.
- `sm_irq_set`  in  `8*NUM_SM`  per-machine IRQ set requests; SM i uses `[8i+7:8i]`.
- `sm_irq_clr`  in  `8*NUM_SM`  per-machine IRQ clear requests, same slicing.
- `irq_flags`  out  8  shared IRQ flag register, fanned out to every `irq_flags_in`.

## Operation
- FSM states: IDLE, IMEM, RESTART, EXEC.
- `cmd_ready` = (state == IDLE) & !reset.
- A command is accepted on a cycle with `cmd_valid & cmd_ready`. Payload is captured on acceptance.
- NOP: stays in IDLE and has no effect.
- IMEM_WR: IDLE→IMEM. In IMEM, `imem_we`=1 with the captured address and data for exactly one cycle, then IMEM→IDLE.
- EN_SET: `sm_en` <= `cmd_data[NUM_SM-1:0]` on the cycle after acceptance. Stays in IDLE.
- RESTART: IDLE→RESTART. `sm_restart`=mask for one cycle, then RESTART→IDLE. `sm_en` is unchanged.
- EXEC: if the target SM is enabled and its index is < `NUM_SM`, go IDLE→EXEC, driving `sm_imm[idx]`=1 and `imm_instr`=data.
  - The controller remains in EXEC until a cycle where `sm_penable[idx]` is 1. `sm_imm` deasserts on the following cycle and the FSM returns to IDLE.
  - If `sm_en[idx]` is cleared while in EXEC, abort to IDLE and pulse `cmd_err`.
  - An EXEC to a disabled SM or an out-of-range index: pulse `cmd_err` the cycle after acceptance and stay in IDLE.
- Reserved opcodes: `cmd_err` pulse and no other effect.
- IRQ register update, every cycle: `flags_next = (flags & ~OR(sm_irq_clr) & ~host_clr) | OR(sm_irq_set)`.
  - Set wins over clear on the same bit in the same cycle.
  - `host_clr` is the IRQ_CLR mask, applied for one cycle, the cycle after acceptance.

## Timing
- Reset values: state IDLE, `sm_en`=0, `sm_restart`=0, `sm_imm`=0, `imm_instr`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `irq_flags`=0, `cmd_err`=0.
- Every output is registered.
- Acceptance at cycle N produces effects as follows:
  - `imem_we` / `sm_restart` / `sm_imm` / `sm_en` / `cmd_err` appear at N+1.
  - `cmd_ready` returns at N+2 for IMEM_WR and RESTART.
  - `cmd_ready` returns one cycle after the `sm_penable` hit for EXEC.
  - `cmd_ready` stays 1 for NOP, EN_SET, IRQ_CLR and all errors.
- IRQ latency: a request at cycle N is visible on `irq_flags` at N+1.
- Reset mid-operation: takes effect at the next edge. All outputs return to reset values and any pending command is dropped.

## Configuration
- `PIO_CTRL_IRQ_EN` defined: the IRQ flag register and IRQ_CLR command are built as described above.
- `PIO_CTRL_IRQ_EN` undefined: `irq_flags` is tied to 0, `sm_irq_*` are ignored, and IRQ_CLR is treated as a reserved opcode (`cmd_err`).

## Structure
- Package `pio_ctrl_pkg` holds the opcode localparams (`OP_NOP` … `OP_IRQ_CLR`) and the FSM state typedef `pio_ctrl_state_t`.
- Sub-module `pio_irq_reg` holds the OR-reduction of per-SM set/clear plus the flag register. It is instantiated only under `PIO_CTRL_IRQ_EN`.

## Test plan
- IMEM_WR addr=5, data=0xE081 → `imem_we`=1 for one cycle with addr 5 and wdata 0xE081. `cmd_ready` is 0 for exactly one cycle.
- EN_SET 0b0101, then RESTART 0b0100 → `sm_en`=0101, `sm_restart`=0100 for one cycle, `sm_en` unchanged.
- EN_SET 0b0010, EXEC idx=1 data=0xA042, `sm_penable[1]` pulsed 4 cycles later → `sm_imm[1]` high until the cycle after that pulse, `imm_instr`=0xA042, then `cmd_ready`=1.
- EXEC idx=2 with `sm_en[2]`=0, and separately `cmd_op`=6 → `cmd_err` pulse in each case, no `sm_imm`, `cmd_ready` stays 1.
- SM0 sets bit 3 while SM1 clears bit 3 in the same cycle → `irq_flags[3]`=1. Next cycle, SM1 clears only → `irq_flags[3]`=0. IRQ_CLR 0xFF clears all flags.
- Reset asserted during EXEC wait → next cycle: all outputs 0, state IDLE.
